// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//
// 32 x 32-bit register file for the processor datapath. One synchronous
// write port (writeback) and two independent combinational read ports
// (decode operands A and B). Register 0 is hardwired to zero.
//
// Ports:
//   clock          in   1   system clock, all state changes on rising edge
//   ctrl_writeEn   in   1   write enable, active-high
//   ctrl_reset     in   1   synchronous active-high reset, clears r1..r31
//   ctrl_writeReg  in   5   write address
//   ctrl_readRegA  in   5   read address, port A
//   ctrl_readRegB  in   5   read address, port B
//   data_writeReg  in  32   write data
//   data_readRegA  out 32   contents of register ctrl_readRegA
//   data_readRegB  out 32   contents of register ctrl_readRegB
// ---------------------------------------------------------------------------
module regfile (
   input  logic        clock,
   input  logic        ctrl_writeEn,
   input  logic        ctrl_reset,
   input  logic [4:0]  ctrl_writeReg,
   input  logic [4:0]  ctrl_readRegA,
   input  logic [4:0]  ctrl_readRegB,
   input  logic [31:0] data_writeReg,
   output logic [31:0] data_readRegA,
   output logic [31:0] data_readRegB
);

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;

   logic [DATA_W-1:0] regs [DEPTH];

   logic writeHit;

   // Writes to r0 are dropped here so the storage for entry 0 stays zero
   // once reset; the read muxes still force zero for address 0 so r0 is
   // correct even before the first reset.
   assign writeHit = ctrl_writeEn && (ctrl_writeReg != 5'd0);

   // Reset takes priority over a write in the same cycle.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (writeHit) begin
         regs[ctrl_writeReg] <= data_writeReg;
      end
   end

   // Reads see stored state only: a same-cycle write becomes visible after
   // the edge that commits it, never before.
   always_comb begin
      data_readRegA = '0;
      if (ctrl_readRegA != 5'd0) begin
         data_readRegA = regs[ctrl_readRegA];
      end
   end

   always_comb begin
      data_readRegB = '0;
      if (ctrl_readRegB != 5'd0) begin
         data_readRegB = regs[ctrl_readRegB];
      end
   end

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
//
// Self-checking bench for regfile. Inputs are driven on the falling edge,
// outputs are sampled 1 time unit after the rising edge (or mid low phase
// for pure reads). Expected read values are pushed to a scoreboard queue
// when the stimulus is driven and popped when the outputs are compared.
// ---------------------------------------------------------------------------
module tb_regfile;

   logic        clock;
   logic        ctrl_writeEn;
   logic        ctrl_reset;
   logic [4:0]  ctrl_writeReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [31:0] data_writeReg;
   logic [31:0] data_readRegA;
   logic [31:0] data_readRegB;

   regfile dut (
      .clock         (clock),
      .ctrl_writeEn  (ctrl_writeEn),
      .ctrl_reset    (ctrl_reset),
      .ctrl_writeReg (ctrl_writeReg),
      .ctrl_readRegA (ctrl_readRegA),
      .ctrl_readRegB (ctrl_readRegB),
      .data_writeReg (data_writeReg),
      .data_readRegA (data_readRegA),
      .data_readRegB (data_readRegB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic        rst;
      logic [4:0]  wAddr;
      logic [31:0] wData;
      logic [4:0]  rA;
      logic [4:0]  rB;
      logic [31:0] expA;
      logic [31:0] expB;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] expA;
      logic [31:0] expB;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   function automatic logic [31:0] pattern(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, 8'hA5, ~b, 8'h5A};
   endfunction

   task automatic checkOne(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Pop the oldest expectation and compare both read ports against it.
   task automatic popCompare();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = sb.pop_front();
         checkOne({e.name, ".A"}, data_readRegA, e.expA);
         checkOne({e.name, ".B"}, data_readRegB, e.expB);
      end
   endtask

   // One clocked cycle: drive at the falling edge, compare after the edge.
   task automatic cycle(input logic we, input logic rst, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [31:0] ea,
                        input logic [31:0] eb, input string name);
      exp_t e;
      @(negedge clock);
      ctrl_writeEn  = we;
      ctrl_reset    = rst;
      ctrl_writeReg = wa;
      data_writeReg = wd;
      ctrl_readRegA = ra;
      ctrl_readRegB = rb;
      e.expA = ea; e.expB = eb; e.name = name;
      sb.push_back(e);
      @(posedge clock);
      #1;
      popCompare();
   endtask

   // Pure read with no write: compared in the low phase, before any edge.
   task automatic readOnly(input logic [4:0] ra, input logic [4:0] rb,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input string name);
      exp_t e;
      @(negedge clock);
      ctrl_writeEn  = 1'b0;
      ctrl_reset    = 1'b0;
      ctrl_readRegA = ra;
      ctrl_readRegB = rb;
      e.expA = ea; e.expB = eb; e.name = name;
      sb.push_back(e);
      #1;
      popCompare();
   endtask

   task automatic write(input logic [4:0] wa, input logic [31:0] wd);
      @(negedge clock);
      ctrl_writeEn  = 1'b1;
      ctrl_reset    = 1'b0;
      ctrl_writeReg = wa;
      data_writeReg = wd;
      @(posedge clock);
      #1;
      ctrl_writeEn  = 1'b0;
   endtask

   initial begin
      exp_t e;

      vecs[0]  = '{1, 0, 5'd5,  32'h12345678, 5'd5,  5'd0,  32'h12345678, 32'h0,        "wr_r5"};
      vecs[1]  = '{0, 0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd0,  32'h12345678, 32'h0,        "we_gate"};
      vecs[2]  = '{1, 0, 5'd3,  32'hAAAA0003, 5'd3,  5'd5,  32'hAAAA0003, 32'h12345678, "wr_r3"};
      vecs[3]  = '{1, 0, 5'd7,  32'h55550007, 5'd3,  5'd7,  32'hAAAA0003, 32'h55550007, "indep"};
      vecs[4]  = '{0, 0, 5'd0,  32'h0,        5'd7,  5'd3,  32'h55550007, 32'hAAAA0003, "swap"};
      vecs[5]  = '{1, 0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        "wr_r0"};
      vecs[6]  = '{1, 0, 5'd9,  32'h00000001, 5'd9,  5'd9,  32'h00000001, 32'h00000001, "wr_r9"};
      vecs[7]  = '{1, 0, 5'd4,  32'h00000044, 5'd4,  5'd9,  32'h00000044, 32'h00000001, "wr_r4"};
      vecs[8]  = '{1, 1, 5'd4,  32'hCAFEBABE, 5'd4,  5'd3,  32'h0,        32'h0,        "rst_prec"};
      vecs[9]  = '{1, 1, 5'd6,  32'h00000011, 5'd6,  5'd0,  32'h0,        32'h0,        "rst_hold"};
      vecs[10] = '{1, 0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        "wr_r31"};

      ctrl_writeEn  = 1'b0;
      ctrl_reset    = 1'b1;
      ctrl_writeReg = '0;
      ctrl_readRegA = '0;
      ctrl_readRegB = '0;
      data_writeReg = '0;

      // Reset held for two edges, with a write attempted throughout.
      cycle(1, 1, 5'd1, 32'hFFFFFFFF, 5'd1, 5'd0, 32'h0, 32'h0, "rst_edge1");
      cycle(1, 1, 5'd2, 32'hFFFFFFFF, 5'd2, 5'd1, 32'h0, 32'h0, "rst_edge2");

      for (int i = 0; i < 32; i++) begin
         readOnly(5'(i), 5'(31 - i), 32'h0, 32'h0, $sformatf("rst_clr[%0d]", i));
      end

      // Write/readback sweep, one register per cycle.
      for (int i = 0; i < 32; i++) begin
         cycle(1, 0, 5'(i), 32'h0000DEAD, 5'(i), 5'(i),
               (i == 0) ? 32'h0 : 32'h0000DEAD,
               (i == 0) ? 32'h0 : 32'h0000DEAD,
               $sformatf("sweep[%0d]", i));
      end

      // Distinct values everywhere, then read back crosswise so any
      // address aliasing or collateral write shows up.
      for (int i = 0; i < 32; i++) write(5'(i), pattern(i));
      for (int i = 0; i < 32; i++) begin
         readOnly(5'(i), 5'(31 - i),
                  (i == 0) ? 32'h0 : pattern(i),
                  (i == 31) ? 32'h0 : pattern(31 - i),
                  $sformatf("uniq[%0d]", i));
      end

      for (int v = 0; v < NVEC; v++) begin
         cycle(vecs[v].we, vecs[v].rst, vecs[v].wAddr, vecs[v].wData,
               vecs[v].rA, vecs[v].rB, vecs[v].expA, vecs[v].expB, vecs[v].name);
      end

      // Same-cycle read/write: old value before the edge, new one after.
      write(5'd9, 32'h00000001);
      @(negedge clock);
      ctrl_writeEn  = 1'b1;
      ctrl_reset    = 1'b0;
      ctrl_writeReg = 5'd9;
      data_writeReg = 32'h00000002;
      ctrl_readRegA = 5'd9;
      ctrl_readRegB = 5'd31;
      e.expA = 32'h1; e.expB = 32'hFFFFFFFF; e.name = "bypass_pre";
      sb.push_back(e);
      e.expA = 32'h2; e.expB = 32'hFFFFFFFF; e.name = "bypass_post";
      sb.push_back(e);
      #3;
      popCompare();
      @(posedge clock);
      #1;
      popCompare();
      ctrl_writeEn = 1'b0;

      // r0 stays zero after an all-ones write.
      write(5'd0, 32'hFFFFFFFF);
      readOnly(5'd0, 5'd9, 32'h0, 32'h2, "r0_zero");

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile.md
# regfile

32-entry by 32-bit register file for the processor datapath, with one synchronous write port and two independent asynchronous read ports. Register 0 is hardwired to zero. The decode stage reads operands through ports A and B. Writeback writes results through the write port on the rising clock edge.

## Interface
- Parameters: none. The width (32 bits) and depth (32 registers) are fixed.
- Clock and reset: one clock; reset is synchronous and active-high.
- Ports, in positional order:
- clock  input  1  system clock; all state changes occur on its rising edge
- ctrl_writeEn  input  1  write enable, active-high
- ctrl_reset  input  1  synchronous active-high reset; clears all registers
- ctrl_writeReg  input  5  write address (0–31)
- ctrl_readRegA  input  5  read address, port A
- ctrl_readRegB  input  5  read address, port B
- data_writeReg  input  32  write data
- data_readRegA  output  32  contents of register ctrl_readRegA
- data_readRegB  output  32  contents of register ctrl_readRegB

## Operation
- Storage: registers r1–r31, each 32 bits. r0 has no storage and always reads 0x00000000.
- Reset:
  - At a rising edge with ctrl_reset=1, r1–r31 all become 0x00000000.
  - Reset has priority over any write in the same cycle.
- Write:
  - At a rising edge with ctrl_reset=0 and ctrl_writeEn=1, data_writeReg is stored into register ctrl_writeReg.
  - A write to address 0 is discarded.
  - With ctrl_writeEn=0, no register changes.
  - Only the addressed register changes; all others hold.
- Read:
  - Purely combinational. data_readRegX = contents of register ctrl_readRegX.
  - Address 0 yields 0x00000000.
  - Ports A and B are fully independent and may address the same register.
- No write-to-read bypass:
  - If a read address matches the write address during a write cycle, the read returns the old value until the rising edge.
  - After the edge, it returns the new value in the same cycle, with combinational delay only.
- No X propagation from storage: every register holds a defined value once the first reset edge has occurred.

## Timing
- Write latency: the new value is visible on the read ports immediately after the rising edge that commits it, i.e. readable before the next edge.
- Read latency: zero cycles, combinational from the address and register state.
- Reset latency: one rising edge.
  - From the edge where ctrl_reset=1 is sampled, all outputs read 0 for any address.
  - Outputs stay 0 until a subsequent write.
- Output reset value: data_readRegA = data_readRegB = 0x00000000 after reset, for every address.
- Holding ctrl_reset high across multiple edges keeps all registers at 0. Writes during those edges are ignored.
- Inputs are expected stable around the rising edge. The intended convention is to drive inputs on the falling edge.

## Test plan
- Reset clear: hold ctrl_reset=1 for 2 edges, then read every address 0–31 on both ports → 0x00000000 everywhere.
- Write/readback sweep: for each index 0–31, write 0x0000DEAD with ctrl_writeEn=1 for one cycle, then read on A and B → r0 reads 0x00000000; r1–r31 read 0x0000DEAD on both ports.
- Write enable gating: write 0x12345678 to r5, then present r5 with 0xFFFFFFFF and ctrl_writeEn=0 for one edge → r5 still reads 0x12345678.
- Independent ports: write r3=0xAAAA0003 and r7=0x5555_0007, then set readRegA=3 and readRegB=7 → A=0xAAAA0003, B=0x55550007. Swap the addresses → the values swap.
- Same-cycle read/write: with readRegA=9 and r9=0x1, write r9=0x2. Before the edge A=0x1; after the edge A=0x2. Write to r0 with 0xFFFFFFFF → r0 still reads 0.
- Reset precedence: assert ctrl_reset=1 and ctrl_writeEn=1 together, writing r4=0xCAFEBABE, after r4 was 0x44 → r4 reads 0x00000000 after the edge.
